// File: rtl/canny_bmp_pkg.sv
// Shared constants and the BMP header byte map for the edge-detect output serializer.
// Header bytes are pure functions of the image geometry, so they live here as one function.
package canny_bmp_pkg;

  localparam int BMP_HEADER_SIZE = 54;
  localparam int BMP_DIB_SIZE    = 40;
  localparam int BMP_PPM         = 2835;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PIX  = 3'd2;
  localparam logic [2:0] S_PAD  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Little-endian field layout of BITMAPFILEHEADER + BITMAPINFOHEADER for 24 bpp.
  function automatic logic [7:0] bmp_header_byte(input logic [5:0]  idx,
                                                 input logic [31:0] width,
                                                 input logic [31:0] height);
    logic [31:0] row_bytes;
    logic [31:0] img_size;
    logic [31:0] field;
    logic [5:0]  base;
    logic [1:0]  sel;
    row_bytes = 32'd3 * width;
    row_bytes = row_bytes + ((32'd4 - (row_bytes % 32'd4)) % 32'd4);
    img_size  = row_bytes * height;
    field     = 32'd0;
    base      = idx;
    if (idx < 6'd2) begin
      field = 32'h0000_4D42;
      base  = 6'd0;
    end else if (idx < 6'd6) begin
      field = 32'(BMP_HEADER_SIZE) + img_size;
      base  = 6'd2;
    end else if (idx < 6'd10) begin
      field = 32'd0;
      base  = 6'd6;
    end else if (idx < 6'd14) begin
      field = 32'(BMP_HEADER_SIZE);
      base  = 6'd10;
    end else if (idx < 6'd18) begin
      field = 32'(BMP_DIB_SIZE);
      base  = 6'd14;
    end else if (idx < 6'd22) begin
      field = width;
      base  = 6'd18;
    end else if (idx < 6'd26) begin
      field = height;
      base  = 6'd22;
    end else if (idx < 6'd28) begin
      field = 32'd1;
      base  = 6'd26;
    end else if (idx < 6'd30) begin
      field = 32'd24;
      base  = 6'd28;
    end else if (idx < 6'd34) begin
      field = 32'd0;
      base  = 6'd30;
    end else if (idx < 6'd38) begin
      field = img_size;
      base  = 6'd34;
    end else if (idx < 6'd42) begin
      field = 32'(BMP_PPM);
      base  = 6'd38;
    end else if (idx < 6'd46) begin
      field = 32'(BMP_PPM);
      base  = 6'd42;
    end
    sel = 2'(idx - base);
    return field[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/bmp_header_gen.sv
// Combinational header ROM: maps a header byte index to its BMP byte for a fixed geometry.
module bmp_header_gen
  import canny_bmp_pkg::*;
#(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic [5:0] idx,
  output logic [7:0] hdr_byte
);

  assign hdr_byte = bmp_header_byte(idx, 32'(WIDTH), 32'(HEIGHT));

endmodule

// File: rtl/bmp_stream_writer.sv
// Drains grayscale pixels into a 24-bpp BMP byte stream: header, 3 copies per pixel, row padding.
// Handshake outputs are combinational so a byte moves in the same cycle both FIFOs allow it.
module bmp_stream_writer #(
  parameter int WIDTH           = 720,
  parameter int HEIGHT          = 540,
  parameter int BMP_HEADER_SIZE = 54
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       img_empty,
  output logic       img_rd_en,
  input  logic [7:0] img_dout,
  input  logic       bmp_full,
  output logic       bmp_wr_en,
  output logic [7:0] bmp_din,
  output logic       busy,
  output logic       done
);

  import canny_bmp_pkg::S_IDLE;
  import canny_bmp_pkg::S_HDR;
  import canny_bmp_pkg::S_PIX;
  import canny_bmp_pkg::S_PAD;
  import canny_bmp_pkg::S_DONE;

  localparam int PAD   = (4 - (3 * WIDTH) % 4) % 4;
  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = $clog2(HEIGHT + 1);

  localparam logic [5:0]       HDR_LAST = 6'(BMP_HEADER_SIZE - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [1:0]       PAD_LAST = 2'(PAD - 1);

  localparam longint unsigned FILE_SIZE =
    64'(BMP_HEADER_SIZE) + 64'(3 * WIDTH + PAD) * 64'(HEIGHT);

  if (WIDTH < 1 || HEIGHT < 1) begin : g_geom_check
    $error("bmp_stream_writer: WIDTH and HEIGHT must be at least 1");
  end
  if (FILE_SIZE >= 64'h1_0000_0000) begin : g_size_check
    $error("bmp_stream_writer: BMP file size does not fit in 32 bits");
  end
  if (BMP_HEADER_SIZE != canny_bmp_pkg::BMP_HEADER_SIZE) begin : g_hdr_check
    $error("bmp_stream_writer: header size is fixed by the BMP format");
  end

  logic [2:0]       state;
  logic [5:0]       hdr_idx;
  logic [1:0]       sub;
  logic [1:0]       pad_cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [7:0]       hdr_byte;
  logic             row_end;

  bmp_header_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_hdr (
    .idx      (hdr_idx),
    .hdr_byte (hdr_byte)
  );

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    bmp_wr_en = 1'b0;
    img_rd_en = 1'b0;
    bmp_din   = 8'h00;
    case (state)
      S_HDR: begin
        bmp_din   = hdr_byte;
        bmp_wr_en = !bmp_full;
      end
      S_PIX: begin
        bmp_din   = img_dout;
        bmp_wr_en = !img_empty && !bmp_full;
        img_rd_en = !img_empty && !bmp_full && (sub == 2'd2);
      end
      S_PAD: bmp_wr_en = !bmp_full;
      default: ;
    endcase
  end

  // A row closes on its last pixel copy when unpadded, otherwise on its last pad byte.
  assign row_end = bmp_wr_en &&
                   (((state == S_PIX) && (sub == 2'd2) && (col == COL_LAST) && (PAD == 0)) ||
                    ((state == S_PAD) && (pad_cnt == PAD_LAST)));

  // NOTE: state uses non-blocking assignments; the later row_end update deliberately overrides the case.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= S_IDLE;
      hdr_idx <= '0;
      sub     <= '0;
      pad_cnt <= '0;
      col     <= '0;
      row     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_HDR;
            hdr_idx <= '0;
            sub     <= '0;
            pad_cnt <= '0;
            col     <= '0;
            row     <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_HDR: begin
          if (bmp_wr_en) begin
            if (hdr_idx == HDR_LAST) begin
              hdr_idx <= '0;
              state   <= S_PIX;
            end else begin
              hdr_idx <= hdr_idx + 6'd1;
            end
          end
        end
        S_PIX: begin
          if (bmp_wr_en) begin
            if (sub != 2'd2) begin
              sub <= sub + 2'd1;
            end else begin
              sub <= '0;
              if (col != COL_LAST) begin
                col <= col + 1'b1;
              end else begin
                col <= '0;
                if (PAD != 0) state <= S_PAD;
              end
            end
          end
        end
        S_PAD: begin
          if (bmp_wr_en) begin
            if (pad_cnt != PAD_LAST) begin
              pad_cnt <= pad_cnt + 2'd1;
            end else begin
              pad_cnt <= '0;
              state   <= S_PIX;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (row_end) begin
        if (row == ROW_LAST) begin
          row   <= '0;
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Directed bench for bmp_stream_writer: two geometries (4x2 unpadded, 3x2 padded) driven
// from behavioural FIFO models, with every byte compared against a bench-side BMP model.
module tb_bmp_stream_writer;

  logic       clk;
  logic       reset;
  logic       start_s     [2];
  logic       img_empty_s [2];
  logic       img_rd_en_s [2];
  logic [7:0] img_dout_s  [2];
  logic       bmp_full_s  [2];
  logic       bmp_wr_en_s [2];
  logic [7:0] bmp_din_s   [2];
  logic       busy_s      [2];
  logic       done_s      [2];

  int         errors = 0;
  int         checks = 0;
  logic [7:0] q[$];
  int         pix_idx, npix, pops, viol;
  logic [7:0] cur_base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bmp_stream_writer #(.WIDTH(4), .HEIGHT(2), .BMP_HEADER_SIZE(54)) dut_a (
    .clock(clk), .reset(reset), .start(start_s[0]),
    .img_empty(img_empty_s[0]), .img_rd_en(img_rd_en_s[0]), .img_dout(img_dout_s[0]),
    .bmp_full(bmp_full_s[0]), .bmp_wr_en(bmp_wr_en_s[0]), .bmp_din(bmp_din_s[0]),
    .busy(busy_s[0]), .done(done_s[0])
  );

  bmp_stream_writer #(.WIDTH(3), .HEIGHT(2), .BMP_HEADER_SIZE(54)) dut_b (
    .clock(clk), .reset(reset), .start(start_s[1]),
    .img_empty(img_empty_s[1]), .img_rd_en(img_rd_en_s[1]), .img_dout(img_dout_s[1]),
    .bmp_full(bmp_full_s[1]), .bmp_wr_en(bmp_wr_en_s[1]), .bmp_din(bmp_din_s[1]),
    .busy(busy_s[1]), .done(done_s[1])
  );

  // Expected byte k of the BMP file for a w x h image whose pixel p has value base+p.
  function automatic logic [7:0] exp_byte(input int k, input int w, input int h,
                                          input logic [7:0] base);
    int         pad, rowb, img, off, c, r;
    int         offs [10];
    int         lens [10];
    int         vals [10];
    logic [7:0] hb   [54];
    pad  = (4 - (3 * w) % 4) % 4;
    rowb = 3 * w + pad;
    img  = rowb * h;
    if (k < 54) begin
      offs = '{2, 10, 14, 18, 22, 26, 28, 34, 38, 42};
      lens = '{4, 4, 4, 4, 4, 2, 2, 4, 4, 4};
      vals = '{54 + img, 54, 40, w, h, 1, 24, img, 2835, 2835};
      for (int i = 0; i < 54; i++) hb[i] = 8'h00;
      hb[0] = 8'h42;
      hb[1] = 8'h4D;
      for (int f = 0; f < 10; f++)
        for (int b = 0; b < lens[f]; b++) hb[offs[f] + b] = 8'(vals[f] >> (8 * b));
      return hb[k];
    end
    off = k - 54;
    r   = off / rowb;
    c   = off % rowb;
    if (c >= 3 * w) return 8'h00;
    return base + 8'(r * w + c / 3);
  endfunction

  // One clock: drive inputs at the falling edge, sample combinational outputs 1 time unit later.
  task automatic step(input int d, input bit emp, input bit full, input bit st);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      start_s[i]     = 1'b0;
      img_empty_s[i] = 1'b1;
      bmp_full_s[i]  = 1'b0;
      img_dout_s[i]  = 8'h00;
    end
    start_s[d]     = st;
    img_empty_s[d] = emp || (pix_idx >= npix);
    bmp_full_s[d]  = full;
    img_dout_s[d]  = cur_base + 8'(pix_idx);
    #1;
    if (bmp_wr_en_s[d] === 1'b1) begin
      if (bmp_full_s[d]) viol++;
      q.push_back(bmp_din_s[d]);
    end
    if (img_rd_en_s[d] === 1'b1) begin
      if (img_empty_s[d]) viol++;
      pix_idx++;
      pops++;
    end
  endtask

  task automatic run_frame(input string tag, input int d, input int w, input int h,
                           input logic [7:0] base, input int emp_pct, input int full_pct,
                           input int busy_start_at, input int hold_at, input int hold_len,
                           input int budget);
    int  total, cyc, final_step, hold_left, freeze_bad, bad, first_bad;
    bit  held, frozen_now, emp, full;
    total = 54 + (3 * w + (4 - (3 * w) % 4) % 4) * h;
    q.delete();
    pix_idx = 0; npix = w * h; pops = 0; viol = 0; cur_base = base;
    cyc = 0; final_step = -1; hold_left = 0; held = 0; freeze_bad = 0;
    step(d, 1'b1, 1'b0, 1'b1);
    do begin
      emp  = ($urandom_range(99) < emp_pct);
      full = ($urandom_range(99) < full_pct);
      if (hold_at >= 0 && !held && q.size() == hold_at) begin
        hold_left = hold_len;
        held      = 1'b1;
      end
      frozen_now = (hold_left > 0);
      if (frozen_now) begin
        full = 1'b1;
        hold_left--;
      end
      step(d, emp, full, cyc == busy_start_at);
      if (frozen_now && (bmp_wr_en_s[d] !== 1'b0 ||
                         bmp_din_s[d] !== exp_byte(hold_at, w, h, base)))
        freeze_bad++;
      if (cyc == 0) begin
        checks++;
        if ({done_s[d], busy_s[d], bmp_din_s[d]} !== {1'b0, 1'b1, 8'h42}) begin
          errors++;
          $display("FAIL %s first_cycle: done,busy,din=%b,%b,%h expected 0,1,42",
                   tag, done_s[d], busy_s[d], bmp_din_s[d]);
        end
      end
      if (final_step < 0 && q.size() >= total) final_step = cyc;
      cyc++;
    end while (done_s[d] !== 1'b1 && cyc < budget);

    checks++;
    if (done_s[d] !== 1'b1 || busy_s[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s end_state: done=%b busy=%b after %0d cycles, expected done=1 busy=0",
               tag, done_s[d], busy_s[d], cyc);
    end
    checks++;
    if (final_step != cyc - 2) begin
      errors++;
      $display("FAIL %s done_latency: last write at cycle %0d, done at %0d, expected 1 apart",
               tag, final_step, cyc - 1);
    end
    checks++;
    if (q.size() != total) begin
      errors++;
      $display("FAIL %s byte_count: got %0d expected %0d", tag, q.size(), total);
    end
    bad = 0; first_bad = -1;
    for (int k = 0; k < total && k < q.size(); k++)
      if (q[k] !== exp_byte(k, w, h, base)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s stream: %0d bad bytes, first at %0d got %h expected %h",
               tag, bad, first_bad, q[first_bad], exp_byte(first_bad, w, h, base));
    end
    checks++;
    if (pops != npix || viol != 0) begin
      errors++;
      $display("FAIL %s handshake: pops=%0d violations=%0d expected pops=%0d violations=0",
               tag, pops, viol, npix);
    end
    if (hold_len > 0) begin
      checks++;
      if (freeze_bad != 0 || !held) begin
        errors++;
        $display("FAIL %s hdr_freeze: %0d stalled cycles moved, hold_seen=%0d expected 0,1",
                 tag, freeze_bad, held);
      end
    end
    for (int i = 0; i < 3; i++) step(d, 1'b0, 1'b0, 1'b0);
    checks++;
    if (done_s[d] !== 1'b1 || q.size() != total) begin
      errors++;
      $display("FAIL %s done_hold: done=%b bytes=%0d expected done=1 bytes=%0d",
               tag, done_s[d], q.size(), total);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    npix  = 0;
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy_s[d], done_s[d], bmp_wr_en_s[d], img_rd_en_s[d], bmp_din_s[d]} !== 12'h000) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: busy,done,wr,rd,din=%b,%b,%b,%b,%h expected all 0",
                 d, busy_s[d], done_s[d], bmp_wr_en_s[d], img_rd_en_s[d], bmp_din_s[d]);
      end
    end
    reset = 1'b1;
    step(0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bmp_wr_en_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: wr=%b busy=%b expected 0,0", bmp_wr_en_s[0], busy_s[0]);
    end
  endtask

  task automatic test_basic();
    logic [7:0] e [4];
    run_frame("basic", 0, 4, 2, 8'h10, 0, 0, -1, -1, 0, 400);
    e = '{8'h4E, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q[2 + i] !== e[i]) begin
        errors++;
        $display("FAIL basic_file_size[%0d]: got %h expected %h", 2 + i, q[2 + i], e[i]);
      end
    end
    for (int i = 54; i < 57; i++) begin
      checks++;
      if (q[i] !== 8'h10) begin
        errors++;
        $display("FAIL basic_first_pixel[%0d]: got %h expected 10", i, q[i]);
      end
    end
    checks++;
    if (q[77] !== 8'h17 || pops != 8) begin
      errors++;
      $display("FAIL basic_last: last=%h pops=%0d expected 17, 8", q[77], pops);
    end
  endtask

  task automatic test_pad();
    logic [7:0] e [4];
    run_frame("pad", 1, 3, 2, 8'h20, 0, 0, -1, -1, 0, 400);
    for (int i = 63; i < 66; i++) begin
      checks++;
      if (q[i] !== 8'h00) begin
        errors++;
        $display("FAIL pad_bytes[%0d]: got %h expected 00", i, q[i]);
      end
    end
    e = '{8'h18, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q[34 + i] !== e[i]) begin
        errors++;
        $display("FAIL pad_image_size[%0d]: got %h expected %h", 34 + i, q[34 + i], e[i]);
      end
    end
    checks++;
    if (q[62] !== 8'h22 || q[66] !== 8'h23) begin
      errors++;
      $display("FAIL pad_row_edges: got %h,%h expected 22,23", q[62], q[66]);
    end
  endtask

  task automatic test_start_busy();
    run_frame("start_busy", 0, 4, 2, 8'h40, 0, 0, 20, -1, 0, 400);
  endtask

  task automatic test_restart();
    run_frame("restart", 0, 4, 2, 8'h80, 0, 0, -1, -1, 0, 400);
  endtask

  task automatic test_hdr_stall();
    run_frame("hdr_stall", 0, 4, 2, 8'hA0, 0, 0, -1, 10, 100, 1000);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      run_frame("random_a", 0, 4, 2, 8'(8'hC0 + n * 16), 30, 50, -1, -1, 0, 3000);
      run_frame("random_b", 1, 3, 2, 8'(8'h60 + n * 16), 30, 50, -1, -1, 0, 3000);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    q.delete();
    pix_idx = 0; npix = 8; pops = 0; viol = 0; cur_base = 8'h10; cyc = 0;
    step(0, 1'b0, 1'b0, 1'b1);
    while (q.size() < 55 && cyc < 200) begin
      step(0, 1'b0, 1'b0, 1'b0);
      cyc++;
    end
    step(0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (q.size() != 55 || bmp_wr_en_s[0] !== 1'b0 || busy_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_setup: bytes=%0d wr=%b busy=%b expected 55,0,1",
               q.size(), bmp_wr_en_s[0], busy_s[0]);
    end
    reset = 1'b0;
    step(0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({busy_s[0], done_s[0], bmp_wr_en_s[0], img_rd_en_s[0], bmp_din_s[0]} !== 12'h000) begin
      errors++;
      $display("FAIL midreset_outputs: busy,done,wr,rd,din=%b,%b,%b,%b,%h expected all 0",
               busy_s[0], done_s[0], bmp_wr_en_s[0], img_rd_en_s[0], bmp_din_s[0]);
    end
    reset = 1'b1;
    step(0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pops != 0 || bmp_wr_en_s[0] !== 1'b0 || q.size() != 55) begin
      errors++;
      $display("FAIL midreset_no_pop: pops=%0d wr=%b bytes=%0d expected 0,0,55",
               pops, bmp_wr_en_s[0], q.size());
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; img_empty_s[i] = 1'b1; bmp_full_s[i] = 1'b0; img_dout_s[i] = 8'h00;
    end
    pix_idx = 0; npix = 0; pops = 0; viol = 0; cur_base = 8'h00;
    test_reset();
    test_basic();
    test_pad();
    test_start_busy();
    test_restart();
    test_hdr_stall();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
